// File: rtl/nonlinear_encryption_module_3.sv
// Keyed nonlinear bit-scrambling stage with a one-cycle registered output.
// Each ciphertext bit is the key-whitened data bit XORed with its cyclic
// upper neighbour gated by the matching key bit.
module nonlinear_encryption_module_3 #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] data_in,
    input  logic [N-1:0] key,
    output logic [N-1:0] data_out,
    output logic         out_valid
);

    logic [N-1:0] whitened;
    logic [N-1:0] mixed;

    assign whitened = data_in ^ key;

    // Neighbour index is resolved at elaboration; bit N-1 wraps to bit 0,
    // and for N = 1 bit 0 is its own neighbour.
    for (genvar i = 0; i < N; i++) begin : g_mix
        localparam int NBR = (i + 1) % N;
        assign mixed[i] = whitened[i] ^ (whitened[NBR] & key[i]);
    end

    // Result register loads only on accepted input; valid follows in_valid every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out <= mixed;
            end
        end
    end

endmodule

// File: tb/tb_nonlinear_encryption_module_3.sv
module tb_nonlinear_encryption_module_3;

    localparam int NDUT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    int          nw    [NDUT] = '{8, 1, 2, 13};
    logic [31:0] din   [NDUT];
    logic [31:0] kin   [NDUT];
    logic        vin   [NDUT];
    logic [31:0] dout  [NDUT];
    logic        vout  [NDUT];
    logic [31:0] exp_d [NDUT];
    logic        exp_v [NDUT];

    logic [7:0]  data_in_8,  key_8,  data_out_8;
    logic [0:0]  data_in_1,  key_1,  data_out_1;
    logic [1:0]  data_in_2,  key_2,  data_out_2;
    logic [12:0] data_in_13, key_13, data_out_13;
    logic        out_valid_8, out_valid_1, out_valid_2, out_valid_13;

    always #5 clk = ~clk;

    assign data_in_8  = din[0][7:0];
    assign key_8      = kin[0][7:0];
    assign data_in_1  = din[1][0:0];
    assign key_1      = kin[1][0:0];
    assign data_in_2  = din[2][1:0];
    assign key_2      = kin[2][1:0];
    assign data_in_13 = din[3][12:0];
    assign key_13     = kin[3][12:0];

    assign dout[0] = {24'b0, data_out_8};
    assign dout[1] = {31'b0, data_out_1};
    assign dout[2] = {30'b0, data_out_2};
    assign dout[3] = {19'b0, data_out_13};
    assign vout[0] = out_valid_8;
    assign vout[1] = out_valid_1;
    assign vout[2] = out_valid_2;
    assign vout[3] = out_valid_13;

    nonlinear_encryption_module_3 #(.N(8)) u_dut_8 (
        .clk(clk), .rst_n(rst_n), .in_valid(vin[0]), .data_in(data_in_8),
        .key(key_8), .data_out(data_out_8), .out_valid(out_valid_8));
    nonlinear_encryption_module_3 #(.N(1)) u_dut_1 (
        .clk(clk), .rst_n(rst_n), .in_valid(vin[1]), .data_in(data_in_1),
        .key(key_1), .data_out(data_out_1), .out_valid(out_valid_1));
    nonlinear_encryption_module_3 #(.N(2)) u_dut_2 (
        .clk(clk), .rst_n(rst_n), .in_valid(vin[2]), .data_in(data_in_2),
        .key(key_2), .data_out(data_out_2), .out_valid(out_valid_2));
    nonlinear_encryption_module_3 #(.N(13)) u_dut_13 (
        .clk(clk), .rst_n(rst_n), .in_valid(vin[3]), .data_in(data_in_13),
        .key(key_13), .data_out(data_out_13), .out_valid(out_valid_13));

    // Reference: bit i = (w[i] + (w[(i+1) mod n] & key[i])) mod 2, w = data ^ key.
    function automatic logic [31:0] ref_enc(input int n, input logic [31:0] d,
                                            input logic [31:0] k);
        logic [31:0] w;
        logic [31:0] c;
        int          s;
        w = d ^ k;
        c = '0;
        for (int i = 0; i < n; i++) begin
            s = int'(w[i]) + int'(w[(i + 1) % n] & k[i]);
            c[i] = ((s % 2) == 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] width_mask(input int n);
        return (n >= 32) ? 32'hffff_ffff : ((32'd1 << n) - 32'd1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string where);
        for (int j = 0; j < NDUT; j++) begin
            check_eq($sformatf("%s_n%0d_data", where, nw[j]), dout[j], exp_d[j]);
            check_eq($sformatf("%s_n%0d_valid", where, nw[j]), 32'(vout[j]), 32'(exp_v[j]));
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < NDUT; j++) begin
            exp_d[j] = '0;
            exp_v[j] = 1'b0;
        end
    endtask

    // One clock edge: update the model as the edge would, then sample after it.
    task automatic step(input string where);
        @(posedge clk);
        if (rst_n) begin
            for (int j = 0; j < NDUT; j++) begin
                exp_v[j] = vin[j];
                if (vin[j]) exp_d[j] = ref_enc(nw[j], din[j], kin[j]);
            end
        end
        #1;
        check_all(where);
    endtask

    task automatic drive8(input logic [7:0] d, input logic [7:0] k, input logic v);
        din[0] = {24'b0, d};
        kin[0] = {24'b0, k};
        vin[0] = v;
        for (int j = 1; j < NDUT; j++) begin
            din[j] = $urandom & width_mask(nw[j]);
            kin[j] = $urandom & width_mask(nw[j]);
            vin[j] = 1'b0;
        end
    endtask

    task automatic drive_random();
        for (int j = 0; j < NDUT; j++) begin
            din[j] = $urandom & width_mask(nw[j]);
            kin[j] = $urandom & width_mask(nw[j]);
            vin[j] = $urandom_range(0, 3) != 0;
        end
    endtask

    logic [7:0] vec_d [6] = '{8'b10101010, 8'b01010101, 8'b00000000,
                              8'b11111111, 8'b00000001, 8'b10010110};
    logic [7:0] vec_k [6] = '{8'b11111111, 8'b00000000, 8'b10101010,
                              8'b01010101, 8'b01010101, 8'b01100101};
    logic [7:0] vec_e [6] = '{8'b11111111, 8'b01010101, 8'b10101010,
                              8'b11111111, 8'b01010100, 8'b10010010};

    initial begin
        for (int j = 0; j < NDUT; j++) begin
            din[j] = '0;
            kin[j] = '0;
            vin[j] = 1'b1;
        end
        model_reset();
        #22;
        check_all("reset");
        rst_n = 1'b1;

        // Directed vectors, one at a time with an idle cycle between them.
        for (int v = 0; v < 6; v++) begin
            drive8(vec_d[v], vec_k[v], 1'b1);
            step($sformatf("vec%0d", v));
            check_eq($sformatf("vec%0d_const", v), dout[0], {24'b0, vec_e[v]});
            check_eq($sformatf("vec%0d_ov", v), 32'(vout[0]), 32'd1);
            if (v != 5) begin
                drive8(8'h00, 8'h00, 1'b0);
                step($sformatf("idle%0d", v));
            end
        end

        // Two idle cycles: valid drops, data holds the last result.
        for (int c = 0; c < 2; c++) begin
            drive8(8'($urandom), 8'($urandom), 1'b0);
            step($sformatf("hold%0d", c));
            check_eq($sformatf("hold%0d_data", c), dout[0], 32'b10010010);
            check_eq($sformatf("hold%0d_ov", c), 32'(vout[0]), 32'd0);
        end

        // Back-to-back stream, then reset mid-stream without a clock edge.
        for (int v = 0; v < 6; v++) begin
            drive8(vec_d[v], vec_k[v], 1'b1);
            step($sformatf("b2b%0d", v));
            check_eq($sformatf("b2b%0d_const", v), dout[0], {24'b0, vec_e[v]});
            check_eq($sformatf("b2b%0d_ov", v), 32'(vout[0]), 32'd1);
        end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("midrst");
        check_eq("midrst_data8", dout[0], 32'd0);
        check_eq("midrst_ov8", 32'(vout[0]), 32'd0);
        #2;
        rst_n = 1'b1;

        // Randomised traffic on all widths.
        for (int c = 0; c < 10000; c++) begin
            drive_random();
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
